// File: rtl/sram_controller_pkg.sv
// Shared definitions for the 16-bit off-chip SRAM initiator.
// Holds the controller state encoding, the default address base and access
// latency, and the SRAM bus widths.
package sram_controller_pkg;

   localparam int unsigned SRAM_AW = 18;
   localparam int unsigned SRAM_DW = 16;

   localparam logic [31:0] DEFAULT_BASE_ADDR     = 32'd1024;
   localparam int unsigned DEFAULT_ACCESS_CYCLES = 6;

   typedef enum logic [2:0] {
      StIdle,
      StLo,
      StHi,
      StWait,
      StDone
   } state_e;

endpackage

// File: rtl/sram_controller.sv
// sram_controller: turns one 32-bit MEM-stage read or write into two 16-bit
// SRAM accesses (low halfword, then high halfword) and stalls the pipeline
// until a fixed total access latency of ACCESS_CYCLES has elapsed.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   wr_en, rd_en  request strobes, held by the pipeline until ready (write wins)
//   address       byte address, word aligned; BASE_ADDR maps to SRAM word 0
//   write_data    word to write
//   read_data     last word read; updates only when a read completes
//   ready         0 stalls the pipeline; 1 when idle or in the completing cycle
//   SRAM_ADDR     SRAM halfword address
//   SRAM_WE_N     SRAM write enable, active-low
//   SRAM_DQ       SRAM data bus, driven only during the two write halves
//
// ACCESS_CYCLES must be at least 4 (IDLE, LO, HI and DONE each take a cycle).
module sram_controller
   import sram_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR     = DEFAULT_BASE_ADDR,
   parameter int unsigned ACCESS_CYCLES = DEFAULT_ACCESS_CYCLES
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] SRAM_ADDR,
   output logic               SRAM_WE_N,
   inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

   localparam int unsigned WaW = SRAM_AW - 1;

   // WAIT lasts ACCESS_CYCLES-4 cycles; the counter runs 0 .. ACCESS_CYCLES-5.
   localparam bit          HasWait  = (ACCESS_CYCLES > 4);
   localparam int unsigned WaitLen  = HasWait ? (ACCESS_CYCLES - 4) : 1;
   localparam int unsigned CntW     = (WaitLen > 1) ? $clog2(WaitLen) : 1;
   localparam logic [CntW-1:0] WaitLast = CntW'(WaitLen - 1);

   state_e            state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WaW-1:0]    wa_q, wa_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              wr_op_q, wr_op_d;
   logic [15:0]       rd_lo_q, rd_lo_d;
   logic [15:0]       rd_hi_q, rd_hi_d;
   logic [31:0]       read_data_q, read_data_d;

   logic              req;
   logic [31:0]       addr_off;
   logic [WaW-1:0]    req_wa;
   logic              dq_oe;
   logic [15:0]       dq_out;
   logic              unused_addr_bits;

   assign req = wr_en | rd_en;

   // Modulo-2^32 offset from the base; word index is bits [18:2], no range check.
   assign addr_off         = address - BASE_ADDR;
   assign req_wa           = addr_off[SRAM_AW:2];
   assign unused_addr_bits = ^{addr_off[31:SRAM_AW+1], addr_off[1:0]};

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wa_d        = wa_q;
      wdata_d     = wdata_q;
      wr_op_d     = wr_op_q;
      rd_lo_d     = rd_lo_q;
      rd_hi_d     = rd_hi_q;
      read_data_d = read_data_q;
      ready       = 1'b0;

      unique case (state_q)
         StIdle: begin
            ready = ~req;
            if (req) begin
               wa_d    = req_wa;
               wdata_d = write_data;
               wr_op_d = wr_en;
               state_d = StLo;
            end
         end
         StLo: begin
            if (!wr_op_q) begin
               rd_lo_d = SRAM_DQ;
            end
            state_d = StHi;
         end
         StHi: begin
            cnt_d = '0;
            if (!wr_op_q) begin
               rd_hi_d = SRAM_DQ;
            end
            if (HasWait) begin
               state_d = StWait;
            end else begin
               state_d = StDone;
               // No WAIT: the high half is on the bus right now.
               if (!wr_op_q) begin
                  read_data_d = {SRAM_DQ, rd_lo_q};
               end
            end
         end
         StWait: begin
            if (cnt_q == WaitLast) begin
               state_d = StDone;
               if (!wr_op_q) begin
                  read_data_d = {rd_hi_q, rd_lo_q};
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         wa_q        <= '0;
         wdata_q     <= '0;
         wr_op_q     <= 1'b0;
         rd_lo_q     <= '0;
         rd_hi_q     <= '0;
         read_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wa_q        <= wa_d;
         wdata_q     <= wdata_d;
         wr_op_q     <= wr_op_d;
         rd_lo_q     <= rd_lo_d;
         rd_hi_q     <= rd_hi_d;
         read_data_q <= read_data_d;
      end
   end

   // Bus outputs decode straight from registered state so reset releases the
   // bus without waiting for a clock edge. The high-half address is held
   // through WAIT and DONE.
   always_comb begin
      dq_oe     = wr_op_q & ((state_q == StLo) | (state_q == StHi));
      dq_out    = (state_q == StHi) ? wdata_q[31:16] : wdata_q[15:0];
      SRAM_WE_N = ~dq_oe;
      SRAM_ADDR = {wa_q, (state_q == StHi) | (state_q == StWait) | (state_q == StDone)};
   end

   assign SRAM_DQ   = dq_oe ? dq_out : {SRAM_DW{1'bz}};
   assign read_data = read_data_q;

endmodule

// File: tb/tb_sram_controller.sv
module tb_sram_controller;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic        sram_we_n;
   wire  [15:0] sram_dq;

   int n_checks = 0;
   int n_errors = 0;

   sram_controller #(
      .BASE_ADDR    (32'd1024),
      .ACCESS_CYCLES(6)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .rd_en     (rd_en),
      .address   (address),
      .write_data(write_data),
      .read_data (read_data),
      .ready     (ready),
      .SRAM_ADDR (sram_addr),
      .SRAM_WE_N (sram_we_n),
      .SRAM_DQ   (sram_dq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // SRAM model: idle bus floats high, so an undriven DQ reads 16'hFFFF.
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup pu (sram_dq[i]);
   end

   logic [15:0] mem [0:262143];
   logic        model_oe;
   logic        mem_fill;

   assign sram_dq = (model_oe && sram_we_n) ? mem[sram_addr] : 16'bz;

   always @(posedge clk) begin
      if (mem_fill) begin
         for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      end else if (!sram_we_n) begin
         mem[sram_addr] <= sram_dq;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard entry: pushed by the stimulus, popped by the monitor at DONE.
   typedef struct {
      logic        is_wr;
      logic [16:0] wa;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        b2b;
   } exp_t;

   exp_t exp_q[$];

   // Monitor: walks each stall window cycle by cycle (k=0 IDLE, 1 LO, 2 HI,
   // 3..4 WAIT) and checks the bus, then checks latency and read_data at DONE.
   initial begin
      int   k;
      logic last_done;
      exp_t e;
      k = 0;
      last_done = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            k = 0;
            last_done = 1'b0;
         end else if (!ready) begin
            if (exp_q.size() > 0) begin
               e = exp_q[0];
               if (k == 0 && e.b2b) chk("b2b_no_bubble", 32'(last_done), 32'd1);
               if (k == 1) begin
                  chk("lo_addr", 32'(sram_addr), 32'({e.wa, 1'b0}));
                  chk("lo_we_n", 32'(sram_we_n), 32'(!e.is_wr));
                  if (e.is_wr) chk("lo_dq", 32'(sram_dq), 32'(e.wdata[15:0]));
               end else if (k == 2) begin
                  chk("hi_addr", 32'(sram_addr), 32'({e.wa, 1'b1}));
                  chk("hi_we_n", 32'(sram_we_n), 32'(!e.is_wr));
                  if (e.is_wr) chk("hi_dq", 32'(sram_dq), 32'(e.wdata[31:16]));
               end else begin
                  chk("idle_wait_we_n", 32'(sram_we_n), 32'd1);
                  if (e.is_wr) chk("idle_wait_dq_z", 32'(sram_dq), 32'h0000FFFF);
                  if (k > 2) chk("wait_addr_held", 32'(sram_addr), 32'({e.wa, 1'b1}));
               end
            end
            k++;
            last_done = 1'b0;
         end else begin
            if (k > 0) begin
               if (exp_q.size() == 0) begin
                  chk("unexpected_done", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk("stall_cycles", 32'(k), 32'd5);
                  chk("read_data", read_data, e.rdata);
               end
               last_done = 1'b1;
            end else begin
               last_done = 1'b0;
            end
            k = 0;
         end
      end
   end

   // Issue one request starting in an IDLE cycle; returns #1 after the edge
   // that closes DONE, with the enables dropped.
   task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] d, input logic [16:0] exp_wa,
                        input logic [31:0] exp_rd, input logic b2b, input logic hold);
      exp_t e;
      bit   done;
      e.is_wr = wr;
      e.wa    = exp_wa;
      e.wdata = d;
      e.rdata = exp_rd;
      e.b2b   = b2b;
      exp_q.push_back(e);
      model_oe   = rd & ~wr;
      wr_en      = wr;
      rd_en      = rd;
      address    = a;
      write_data = d;
      if (!hold) begin
         @(posedge clk);
         #1;
         wr_en = 1'b0;
         rd_en = 1'b0;
      end
      done = 1'b0;
      for (int n = 0; n < 20 && !done; n++) begin
         @(negedge clk);
         if (ready) done = 1'b1;
      end
      if (!done) chk("completion_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      wr_en    = 1'b0;
      rd_en    = 1'b0;
      model_oe = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      mem_fill   = 1'b1;
      model_oe   = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      address    = 32'd0;
      write_data = 32'd0;
      #2;
      chk("rst_ready", 32'(ready), 32'd1);
      chk("rst_read_data", read_data, 32'd0);
      chk("rst_we_n", 32'(sram_we_n), 32'd1);
      chk("rst_dq_z", 32'(sram_dq), 32'h0000FFFF);
      chk("rst_addr", 32'(sram_addr), 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      mem_fill = 1'b0;
      rst      = 1'b0;
      @(posedge clk);
      #1;

      // Write DEADBEEF to word 0, then read it back.
      issue(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 17'd0, 32'h00000000, 1'b0, 1'b1);
      chk("mem0", 32'(mem[0]), 32'h0000BEEF);
      chk("mem1", 32'(mem[1]), 32'h0000DEAD);
      @(posedge clk);
      #1;
      issue(1'b0, 1'b1, 32'd1024, 32'h0, 17'd0, 32'hDEADBEEF, 1'b0, 1'b1);
      @(posedge clk);
      #1;

      // Back-to-back: the read is presented in the IDLE cycle right after DONE.
      issue(1'b1, 1'b0, 32'd1028, 32'h12345678, 17'd1, 32'hDEADBEEF, 1'b0, 1'b1);
      issue(1'b0, 1'b1, 32'd1028, 32'h0, 17'd1, 32'h12345678, 1'b1, 1'b1);
      chk("mem2", 32'(mem[2]), 32'h00005678);
      chk("mem3", 32'(mem[3]), 32'h00001234);
      @(posedge clk);
      #1;

      // Both enables high: write wins, read_data unchanged.
      issue(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D, 17'd2, 32'h12345678, 1'b0, 1'b1);
      chk("mem4", 32'(mem[4]), 32'h0000F00D);
      chk("mem5", 32'(mem[5]), 32'h0000CAFE);
      @(posedge clk);
      #1;

      // Enable dropped after the IDLE cycle: completes on latched values.
      issue(1'b1, 1'b0, 32'd1040, 32'h0BADF00D, 17'd4, 32'h12345678, 1'b0, 1'b0);
      chk("mem8", 32'(mem[8]), 32'h0000F00D);
      chk("mem9", 32'(mem[9]), 32'h00000BAD);
      @(posedge clk);
      #1;

      // Reset asserted during HI of a write.
      wr_en      = 1'b1;
      address    = 32'd1036;
      write_data = 32'h55AA33CC;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("pre_rst_we_n_hi", 32'(sram_we_n), 32'd0);
      rst = 1'b1;
      #1;
      chk("midrst_we_n", 32'(sram_we_n), 32'd1);
      chk("midrst_dq_z", 32'(sram_dq), 32'h0000FFFF);
      chk("midrst_read_data", read_data, 32'd0);
      wr_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 32'(ready), 32'd1);
      chk("mem6_partial", 32'(mem[6]), 32'h000033CC);
      chk("mem7_unwritten", 32'(mem[7]), 32'h00000000);
      @(posedge clk);
      #1;
      issue(1'b0, 1'b1, 32'd1024, 32'h0, 17'd0, 32'hDEADBEEF, 1'b0, 1'b1);

      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Initiator side of the 16-bit off-chip SRAM interface. Sits between the pipeline MEM stage and the SRAM.
- Converts one 32-bit word read or write into two 16-bit SRAM accesses, low half then high half.
- Holds `ready` low to freeze the pipeline until a fixed access latency has elapsed.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- ACCESS_CYCLES, 6: total cycles per request, counted from the IDLE cycle in which the request is seen up to and including the DONE cycle. Minimum 4.

Ports:
- clk  input  1  clock. Period must be ≥10 ns (SRAM read delay is 7 ns plus setup).
- rst  input  1  reset, asynchronous, active-high.
- wr_en  input  1  write request, held by the pipeline until `ready`.
- rd_en  input  1  read request, held by the pipeline until `ready`.
- address  input  32  byte address, word aligned.
- write_data  input  32  word to write.
- read_data  output  32  last word read.
- ready  output  1  0 = stall the pipeline; 1 = idle or request completing.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  SRAM write enable, active-low.
- SRAM_DQ  inout  16  SRAM data bus.

Behaviour:
- Reset (asynchronous): state=IDLE, wait counter=0, read_data=0, SRAM_WE_N=1, SRAM_DQ=Z, SRAM_ADDR=0. Latched address and data registers are cleared.
- Address map:
  - wa = (address − BASE_ADDR) >> 2, truncated to 17 bits; arithmetic is modulo 2^32, no range check.
  - Low half goes to SRAM_ADDR = {wa,0}; high half goes to {wa,1}.
- Request priority: wr_en wins when wr_en and rd_en are both high.
- ready = 0 when (state==IDLE and (wr_en|rd_en)) or state ∈ {LO, HI, WAIT}. ready = 1 in DONE, and in IDLE with no request.
- FSM:
  - IDLE:
    - On request, latch address, write_data and op (write/read); go to LO.
    - Bus idle: WE_N=1, DQ=Z.
  - LO:
    - SRAM_ADDR={wa,0}.
    - Write: WE_N=0, DQ=wdata[15:0]; the SRAM stores on the closing edge.
    - Read: WE_N=1, DQ=Z; capture DQ into rd_lo on the closing edge.
    - Next state: HI.
  - HI:
    - Same as LO with {wa,1} and wdata[31:16] / rd_hi.
    - Next state: WAIT if ACCESS_CYCLES>4, else DONE.
  - WAIT:
    - WE_N=1, DQ=Z, SRAM_ADDR held.
    - Counter runs ACCESS_CYCLES−4 cycles, then the FSM goes to DONE.
  - DONE:
    - ready=1.
    - If the op was a read, read_data={rd_hi,rd_lo}, registered on entry to DONE so it is valid during DONE.
    - Next state: IDLE unconditionally. A request is never re-triggered in DONE.
- Latency: ready is 0 for exactly ACCESS_CYCLES−1 cycles and 1 in the ACCESS_CYCLES-th cycle (default 5 stalled + 1).
- Back-to-back requests: a new request seen in the IDLE cycle right after DONE starts immediately. No extra bubble beyond the IDLE cycle.
- read_data holds its value across writes and idle cycles and changes only on completion of a read.
- SRAM_DQ is driven only in LO/HI of a write; it is Z in every other state and during reset.
- Request dropped mid-operation (pipeline deasserts the enable): the access still completes on the latched values.
- Reset mid-operation:
  - Immediate return to IDLE; WE_N goes to 1 and DQ to Z without waiting for a clock edge.
  - A partially written word is not repaired.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, LO, HI, WAIT, DONE);
  - BASE_ADDR and ACCESS_CYCLES defaults;
  - SRAM_AW=18 and SRAM_DW=16 width constants.
- Single module, no sub-module. The wait counter and address map are in-line.

Test Plan (bench instantiates this block with the team's SRAM model, shared clk/rst):
- Reset: assert rst → ready=1 (no request), read_data=0, SRAM_WE_N=1, SRAM_DQ=Z.
- Write: wr_en=1, address=1024, write_data=0xDEADBEEF → ready low 5 cycles, high 6th; SRAM mem[0]=0xBEEF, mem[1]=0xDEAD; WE_N low only in LO and HI.
- Read: rd_en=1, address=1024 after the write above → read_data=0xDEADBEEF in the DONE cycle; WE_N=1 throughout; SRAM_ADDR 0 then 1.
- Back-to-back: write 0x12345678 to 1028, then a read of 1028 asserted in the cycle after ready → SRAM_ADDR 2/3; read_data=0x12345678; the second request's ready low starts in the cycle after DONE.
- Priority: wr_en=rd_en=1, address=1032, write_data=0xCAFEF00D → mem[4]=0xF00D, mem[5]=0xCAFE; read_data unchanged.
- Reset mid-access: assert rst during HI of a write → same cycle WE_N=1, DQ=Z, read_data=0; IDLE after release; the next request completes in 6 cycles.
